// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM states, bus widths and the byte-strobe merge helper.
package apb_pkg;

    localparam int APB_DATA_W = 32;
    localparam int APB_STRB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } apb_state_t;

    // Replace each byte of old whose strobe bit is set with the matching wdata byte.
    function automatic logic [APB_DATA_W-1:0] strb_merge(
        input logic [APB_DATA_W-1:0] old,
        input logic [APB_DATA_W-1:0] wdata,
        input logic [APB_STRB_W-1:0] strb
    );
        logic [APB_DATA_W-1:0] res;
        res = old;
        for (int b = 0; b < APB_STRB_W; b++) begin
            if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Down-counter that paces the wait states of one APB transfer.
module apb_wait_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] val_i,
    input  logic             dec_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;

    // Load on transfer start, then count down towards zero (saturating).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= val_i;
        end else if (dec_i && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Last wait cycle: the FSM moves to RESP on the following edge.
    assign done_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/apb_regfile_slave.sv
// Parametrised APB4 register file: byte strobes, wait states, PSLVERR on
// out-of-range or read-only writes, hardware-sourced read-only slots.
module apb_regfile_slave
    import apb_pkg::*;
#(
    parameter int                             ADDR_W      = 8,
    parameter int                             NUM_REGS    = 8,
    parameter int                             WAIT_CYCLES = 0,
    parameter logic [NUM_REGS-1:0]            RO_MASK     = '0,
    parameter logic [NUM_REGS*APB_DATA_W-1:0] RESET_VAL   = '0
) (
    input  logic                           PCLK,
    input  logic                           PRESET,
    input  logic [ADDR_W-1:0]              PADDR,
    input  logic [APB_DATA_W-1:0]          PWDATA,
    input  logic                           PWRITE,
    input  logic                           PSEL,
    input  logic                           PENABLE,
    input  logic [APB_STRB_W-1:0]          PSTRB,
    output logic [APB_DATA_W-1:0]          PRDATA,
    output logic                           PREADY,
    output logic                           PSLVERR,
    output logic [NUM_REGS*APB_DATA_W-1:0] reg_q,
    output logic [NUM_REGS-1:0]            wr_pulse,
    input  logic [NUM_REGS*APB_DATA_W-1:0] hw_rdata
);

    localparam int IDX_W = ADDR_W - 2;

    apb_state_t             state_q, state_d;
    logic [IDX_W-1:0]       idx_q;
    logic                   write_q;
    logic [APB_DATA_W-1:0]  wdata_q;
    logic [APB_STRB_W-1:0]  strb_q;
    logic [APB_DATA_W-1:0]  regs_q [NUM_REGS];

    logic [APB_DATA_W-1:0]  prdata_q;
    logic                   pready_q, pslverr_q;
    logic [NUM_REGS-1:0]    wr_pulse_q;

    logic                   tmr_load, tmr_dec, tmr_done;

    // Byte-offset bits carry no information for word registers.
    logic unused_paddr;
    assign unused_paddr = ^PADDR[1:0];

    // With no wait states the commit happens on the same edge that samples
    // the access, so the bus is used directly while IDLE; otherwise the
    // captured copy is used.
    logic                   acc_idle;
    logic [IDX_W-1:0]       acc_idx;
    logic                   acc_write;
    logic [APB_DATA_W-1:0]  acc_wdata;
    logic [APB_STRB_W-1:0]  acc_strb;

    assign acc_idle  = (state_q == IDLE);
    assign acc_idx   = acc_idle ? PADDR[ADDR_W-1:2] : idx_q;
    assign acc_write = acc_idle ? PWRITE  : write_q;
    assign acc_wdata = acc_idle ? PWDATA  : wdata_q;
    assign acc_strb  = acc_idle ? PSTRB   : strb_q;

    logic [NUM_REGS-1:0]    sel;
    logic [APB_DATA_W-1:0]  rd_val;
    logic                   in_range, ro_hit, err, commit;

    // One-hot register decode and read mux; empty select means out of range.
    always_comb begin
        sel    = '0;
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(acc_idx) == i) begin
                sel[i] = 1'b1;
                rd_val = RO_MASK[i] ? hw_rdata[i*APB_DATA_W +: APB_DATA_W] : regs_q[i];
            end
        end
    end

    assign in_range = |sel;
    assign ro_hit   = |(sel & RO_MASK);
    assign err      = !in_range || (acc_write && ro_hit);
    assign commit   = (state_d == RESP) && (state_q != RESP);

    apb_wait_timer #(.CNT_W(4)) u_timer (
        .clk_i  (PCLK),
        .rst_i  (PRESET),
        .load_i (tmr_load),
        .val_i  (4'(WAIT_CYCLES)),
        .dec_i  (tmr_dec),
        .done_o (tmr_done)
    );

    // FSM state register.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and timer control; RESP ignores PSEL/PENABLE so a held
    // access cannot be acknowledged twice.
    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (PSEL && PENABLE) begin
                    tmr_load = 1'b1;
                    state_d  = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                tmr_dec = 1'b1;
                if (tmr_done) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture the transfer so it completes even if PSEL drops during WAIT.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            idx_q   <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else if (acc_idle && PSEL && PENABLE) begin
            idx_q   <= PADDR[ADDR_W-1:2];
            write_q <= PWRITE;
            wdata_q <= PWDATA;
            strb_q  <= PSTRB;
        end
    end

    // Register array: strobed write on a successful commit only.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL[i*APB_DATA_W +: APB_DATA_W];
        end else if (commit && acc_write && !err) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (sel[i] && !RO_MASK[i]) regs_q[i] <= strb_merge(regs_q[i], acc_wdata, acc_strb);
            end
        end
    end

    // Response outputs, registered on the edge entering RESP; PRDATA holds otherwise.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            prdata_q   <= '0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            wr_pulse_q <= '0;
        end else begin
            pready_q   <= commit;
            pslverr_q  <= commit && err;
            wr_pulse_q <= (commit && acc_write && !err) ? sel : '0;
            if (commit) prdata_q <= (acc_write || err) ? '0 : rd_val;
        end
    end

    assign PRDATA   = prdata_q;
    assign PREADY   = pready_q;
    assign PSLVERR  = pslverr_q;
    assign wr_pulse = wr_pulse_q;

    // Expose RW contents; read-only slots have no storage of interest and read 0.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regq
        assign reg_q[g*APB_DATA_W +: APB_DATA_W] = RO_MASK[g] ? '0 : regs_q[g];
    end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Bench for apb_regfile_slave: two instances (no waits / RW only, and three
// waits with register 2 read-only) driven from one bus with separate selects.
module tb_apb_regfile_slave;

    localparam logic [255:0] RV = {32'h0, 32'h0, 32'h5A5AA5A5, 32'h0,
                                   32'h33330003, 32'h0, 32'h0, 32'h0};
    localparam int           NW [2] = '{0, 3};
    localparam logic [7:0]   ROM[2] = '{8'h00, 8'h04};

    logic         clk = 1'b0;
    logic         prst;
    logic [7:0]   paddr;
    logic [31:0]  pwdata;
    logic         pwrite, penable;
    logic [1:0]   psel;
    logic [3:0]   pstrb;
    logic [31:0]  prdata [2];
    logic [1:0]   pready, pslverr;
    logic [255:0] regq [2];
    logic [7:0]   wrp [2];
    logic [255:0] hw;

    int nvec = 0;
    int nerr = 0;
    logic [31:0] mreg [2][8];

    always #5 clk = ~clk;

    apb_regfile_slave #(.ADDR_W(8), .NUM_REGS(8), .WAIT_CYCLES(0),
                        .RO_MASK(8'h00), .RESET_VAL(RV)) dut0 (
        .PCLK(clk), .PRESET(prst), .PADDR(paddr), .PWDATA(pwdata), .PWRITE(pwrite),
        .PSEL(psel[0]), .PENABLE(penable), .PSTRB(pstrb), .PRDATA(prdata[0]),
        .PREADY(pready[0]), .PSLVERR(pslverr[0]), .reg_q(regq[0]),
        .wr_pulse(wrp[0]), .hw_rdata(hw));

    apb_regfile_slave #(.ADDR_W(8), .NUM_REGS(8), .WAIT_CYCLES(3),
                        .RO_MASK(8'h04), .RESET_VAL(RV)) dut3 (
        .PCLK(clk), .PRESET(prst), .PADDR(paddr), .PWDATA(pwdata), .PWRITE(pwrite),
        .PSEL(psel[1]), .PENABLE(penable), .PSTRB(pstrb), .PRDATA(prdata[1]),
        .PREADY(pready[1]), .PSLVERR(pslverr[1]), .reg_q(regq[1]),
        .wr_pulse(wrp[1]), .hw_rdata(hw));

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 8; i++) mreg[d][i] = RV[i*32 +: 32];
    endtask

    function automatic logic [255:0] model_image(input int d);
        logic [255:0] img;
        img = '0;
        for (int i = 0; i < 8; i++) img[i*32 +: 32] = ROM[d][i] ? 32'h0 : mreg[d][i];
        return img;
    endfunction

    // Transfer-level reference: word index, bounds, read-only rule, strobed bytes.
    task automatic model(input int d, input logic [7:0] a, input logic w,
                         input logic [31:0] wd, input logic [3:0] st,
                         output logic [31:0] er, output logic ee, output logic [7:0] ep);
        int idx;
        idx = int'(a) / 4;
        er = 32'h0; ee = 1'b0; ep = 8'h0;
        if (idx >= 8) begin
            ee = 1'b1;
        end else if (w) begin
            if (ROM[d][idx]) ee = 1'b1;
            else begin
                for (int b = 0; b < 4; b++)
                    if (st[b]) mreg[d][idx][8*b +: 8] = wd[8*b +: 8];
                ep = 8'(1 << idx);
            end
        end else begin
            er = ROM[d][idx] ? hw[idx*32 +: 32] : mreg[d][idx];
        end
    endtask

    // Full APB transfer on instance d; access phase is held one cycle past
    // PREADY to show RESP does not acknowledge twice.
    task automatic do_xfer(input int d, input logic [7:0] a, input logic w,
                           input logic [31:0] wd, input logic [3:0] st,
                           input logic [31:0] er, input logic ee, input logic [7:0] ep);
        int lat;
        bit got;
        @(negedge clk);
        paddr = a; pwrite = w; pwdata = wd; pstrb = st; psel[d] = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        lat = 0; got = 0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (pready[d]) got = 1;
        end
        chk("latency", 256'(lat), 256'(1 + NW[d]));
        if (got) begin
            chk("prdata",   256'(prdata[d]),  256'(er));
            chk("pslverr",  256'(pslverr[d]), 256'(ee));
            chk("wr_pulse", 256'(wrp[d]),     256'(ep));
            @(negedge clk);
            chk("second pready", 256'(pready[d]), 256'(0));
            chk("pulse width",   256'(wrp[d]),    256'(0));
            chk("pslverr idle",  256'(pslverr[d]), 256'(0));
            chk("prdata hold",   256'(prdata[d]), 256'(er));
        end
        psel[d] = 1'b0; penable = 1'b0;
        chk("reg_q", regq[d], model_image(d));
    endtask

    typedef struct {
        int          d;
        logic [7:0]  a;
        logic        w;
        logic [31:0] wd;
        logic [3:0]  st;
        logic [31:0] er;
        logic        ee;
        logic [7:0]  ep;
    } vec_t;

    vec_t tbl [17];

    initial begin
        logic [31:0] er;
        logic ee;
        logic [7:0] ep, a;
        logic [31:0] wd;
        logic [3:0] st;
        logic w;
        int d;

        tbl[0]  = '{0, 8'h04, 1'b1, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 8'h02};
        tbl[1]  = '{0, 8'h04, 1'b0, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 8'h00};
        tbl[2]  = '{0, 8'h08, 1'b1, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0, 8'h04};
        tbl[3]  = '{0, 8'h08, 1'b0, 32'h0,        4'hF, 32'h00BB00DD, 1'b0, 8'h00};
        tbl[4]  = '{0, 8'h0C, 1'b1, 32'h11223344, 4'h0, 32'h0,        1'b0, 8'h08};
        tbl[5]  = '{0, 8'h0D, 1'b0, 32'h0,        4'h0, 32'h33330003, 1'b0, 8'h00};
        tbl[6]  = '{0, 8'h20, 1'b1, 32'h55555555, 4'hF, 32'h0,        1'b1, 8'h00};
        tbl[7]  = '{0, 8'h20, 1'b0, 32'h0,        4'h0, 32'h0,        1'b1, 8'h00};
        tbl[8]  = '{0, 8'h14, 1'b0, 32'h0,        4'h0, 32'h5A5AA5A5, 1'b0, 8'h00};
        tbl[9]  = '{0, 8'hFC, 1'b0, 32'h0,        4'h0, 32'h0,        1'b1, 8'h00};
        tbl[10] = '{1, 8'h00, 1'b0, 32'h0,        4'h0, 32'h0,        1'b0, 8'h00};
        tbl[11] = '{1, 8'h08, 1'b0, 32'h0,        4'h0, 32'h12345678, 1'b0, 8'h00};
        tbl[12] = '{1, 8'h08, 1'b1, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1, 8'h00};
        tbl[13] = '{1, 8'h08, 1'b0, 32'h0,        4'h0, 32'h12345678, 1'b0, 8'h00};
        tbl[14] = '{1, 8'h1C, 1'b1, 32'hCAFEF00D, 4'h8, 32'h0,        1'b0, 8'h80};
        tbl[15] = '{1, 8'h1C, 1'b0, 32'h0,        4'h0, 32'hCA000000, 1'b0, 8'h00};
        tbl[16] = '{1, 8'h24, 1'b0, 32'h0,        4'h0, 32'h0,        1'b1, 8'h00};

        hw = {32'h77777777, 32'h66666666, 32'h55550000, 32'h44444444,
              32'h33333333, 32'h12345678, 32'h11111111, 32'h00000001};
        prst = 1'b1; paddr = '0; pwdata = '0; pwrite = 1'b0; penable = 1'b0;
        psel = '0; pstrb = '0;
        model_reset();
        repeat (3) @(negedge clk);
        prst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 2; i++) begin
            chk("reset pready",   256'(pready[i]),  256'(0));
            chk("reset pslverr",  256'(pslverr[i]), 256'(0));
            chk("reset prdata",   256'(prdata[i]),  256'(0));
            chk("reset wr_pulse", 256'(wrp[i]),     256'(0));
            chk("reset reg_q",    regq[i],          model_image(i));
        end

        // Directed table; the model runs alongside to track register contents.
        for (int i = 0; i < 17; i++) begin
            model(tbl[i].d, tbl[i].a, tbl[i].w, tbl[i].wd, tbl[i].st, er, ee, ep);
            do_xfer(tbl[i].d, tbl[i].a, tbl[i].w, tbl[i].wd, tbl[i].st,
                    tbl[i].er, tbl[i].ee, tbl[i].ep);
        end

        // Reset during the wait phase of a write to reg3 on the waited instance.
        @(negedge clk);
        paddr = 8'h0C; pwrite = 1'b1; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
        psel[1] = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        chk("pready in wait", 256'(pready[1]), 256'(0));
        prst = 1'b1; psel[1] = 1'b0; penable = 1'b0;
        model_reset();
        #1;
        chk("async reset pready",   256'(pready[1]), 256'(0));
        chk("async reset reg_q3",   256'(regq[1]),   256'(model_image(1)));
        chk("async reset reg_q0",   256'(regq[0]),   256'(model_image(0)));
        @(negedge clk);
        prst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no pready after reset", 256'(pready[1]), 256'(0));
            chk("no pulse after reset",  256'(wrp[1]),    256'(0));
        end
        model(1, 8'h0C, 1'b0, 32'h0, 4'h0, er, ee, ep);
        do_xfer(1, 8'h0C, 1'b0, 32'h0, 4'h0, 32'h33330003, 1'b0, 8'h00);

        // Randomised transfers against the reference model.
        for (int i = 0; i < 80; i++) begin
            d  = int'($urandom_range(0, 1));
            a  = 8'($urandom_range(0, 47));
            w  = 1'($urandom_range(0, 1));
            wd = $urandom;
            st = 4'($urandom_range(0, 15));
            model(d, a, w, wd, st, er, ee, ep);
            do_xfer(d, a, w, wd, st, er, ee, ep);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/apb_regfile_slave.md
Name: apb_regfile_slave

Overview:
- Parametrised successor to the team's fixed 4-register APB slave.
- Provides NUM_REGS 32-bit registers with APB4 byte strobes and programmable wait states.
- Reports PSLVERR on out-of-range or read-only accesses.
- Exposes register contents, per-register write pulses and read-only hardware inputs to the attached peripheral logic.

Parameters:
- ADDR_W, 8, PADDR width; word index = PADDR[ADDR_W-1:2], PADDR[1:0] ignored.
- NUM_REGS, 8, number of 32-bit registers (1..2^(ADDR_W-2)).
- WAIT_CYCLES, 0, extra access-phase cycles before PREADY (0..15).
- RO_MASK, '0, NUM_REGS-bit mask; bit i=1 makes register i read-only (sourced from hw_rdata).
- RESET_VAL, '0, NUM_REGS*32-bit flattened reset value of RW registers.

Ports:
- PCLK  in  1  clock
- PRESET  in  1  asynchronous active-high reset
- PADDR  in  ADDR_W  byte address
- PWDATA  in  32  write data
- PWRITE  in  1  1=write, 0=read
- PSEL  in  1  slave select
- PENABLE  in  1  access phase
- PSTRB  in  4  byte write strobes
- PRDATA  out  32  read data, valid with PREADY
- PREADY  out  1  transfer complete, one-cycle pulse
- PSLVERR  out  1  error, valid only with PREADY
- reg_q  out  NUM_REGS*32  current RW register values (RO slots read 0)
- wr_pulse  out  NUM_REGS  one-cycle pulse when register i is successfully written
- hw_rdata  in  NUM_REGS*32  read source for RO registers

Behaviour:
- One clock, PCLK; reset PRESET is asynchronous and active-high.
- Reset values: all outputs registered and cleared to 0; RW registers load RESET_VAL; FSM goes to IDLE.
- FSM states: IDLE, WAIT, RESP.
- IDLE: on PSEL&&PENABLE, capture addr/write/data/strb and load wait counter with WAIT_CYCLES. Go to WAIT if WAIT_CYCLES>0, else RESP.
- WAIT: decrement counter each cycle; at count 1, go to RESP.
- RESP: PREADY=1 for exactly one cycle, then return to IDLE unconditionally. PSEL/PENABLE sampled during RESP are ignored, so there is no double-acknowledge.
- Latency: access phase starts at edge T; PREADY is high during cycle T+1+WAIT_CYCLES.
- Commit: register update, wr_pulse, PRDATA and PSLVERR are all registered on the edge entering RESP.
- Error: idx >= NUM_REGS -> PSLVERR=1, PRDATA=0, no state change.
- Error: write to an RO_MASK register -> PSLVERR=1, no change, no wr_pulse.
- Write OK: for each byte b with PSTRB[b]=1, reg[idx][8b+7:8b] <= PWDATA byte b. wr_pulse[idx]=1, even when PSTRB=0 (no data change in that case).
- Read OK: PRDATA = RO ? hw_rdata slice : reg[idx]. PSTRB is ignored on reads.
- On a write, PRDATA=0.
- Outside RESP, PREADY=0 and PSLVERR=0; PRDATA holds its last value.
- PSEL deasserted mid-WAIT (protocol violation): transfer completes anyway.
- Reset mid-transfer: immediate return to IDLE with all outputs 0; pending write discarded.
- Back-to-back transfers: the next access phase can begin the cycle after RESP (IDLE samples it).

Decomposition:
- Shared package apb_pkg holds:
  - typedef enum logic [1:0] {IDLE, WAIT, RESP} apb_state_t;
  - APB_DATA_W=32, APB_STRB_W=4;
  - function strb_merge(old, wdata, strb).
- Sub-module apb_wait_timer (4-bit down-counter with load/done) is natural; everything else stays in the top level.

Test Plan:
- Defaults, write 0x0000_0004 <= 0xDEAD_BEEF with PSTRB=4'hF, then read -> PREADY at T+1, PRDATA=0xDEADBEEF, wr_pulse[1] one cycle, PSLVERR=0.
- Write 0x8 <= 0xAABBCCDD with PSTRB=4'b0101 over reset value 0 -> read returns 0x00BB00DD.
- WAIT_CYCLES=3, read reg0 -> PREADY exactly one cycle, at T+4; PSEL/PENABLE held through RESP gives no second PREADY.
- NUM_REGS=8, access addr 0x20 -> PSLVERR=1 with PREADY, PRDATA=0, no wr_pulse.
- RO_MASK=8'h04, hw_rdata[2]=0x1234_5678: read 0x8 -> 0x12345678; write 0x8 -> PSLVERR=1, read still 0x12345678.
- Assert PRESET during WAIT of a write to reg3 -> PREADY stays 0, reg3 = RESET_VAL, FSM in IDLE; next transfer completes normally.
